// File: rtl/mcu_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu_spi_pkg
// Brief    : Shared types and constants for the MCU-style SPI initiator.
// Revision : 1.0 - initial release
// ============================================================================
package mcu_spi_pkg;

   // Frame sequencer states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      HI    = 3'd2,
      LO    = 3'd3,
      LOAD  = 3'd4,
      HOLD  = 3'd5,
      GAP   = 3'd6
   } spi_state_e;

   // Well-known target-ID bytes
   localparam logic [7:0] TARGET_HID = 8'd1;
   localparam logic [7:0] TARGET_OSD = 8'd2;

endpackage
`default_nettype wire

// File: rtl/mcu_spi_master_shift8.sv
`default_nettype none
// ============================================================================
// Module   : spi_shift8
// Brief    : 8-bit full-duplex shift register with a 3-bit bit counter.
//            byte_done is true when the counter has wrapped back to zero,
//            i.e. all eight bits of the current byte have been shifted.
// Revision : 1.0 - initial release
// ============================================================================
module spi_shift8 (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       shift,
   input  logic       din,
   output logic       msb,
   output logic [7:0] data,
   output logic       byte_done
);

   logic [7:0] sr_q, sr_d;
   logic [2:0] cnt_q, cnt_d;

   // Load takes priority; a shift moves MSB out and din in at the bottom
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load) begin
         sr_d  = load_data;
         cnt_d = 3'd0;
      end else if (shift) begin
         sr_d  = {sr_q[6:0], din};
         cnt_d = cnt_q + 3'd1;
      end
   end

   // Shift register and bit counter state
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q  <= 8'd0;
         cnt_q <= 3'd0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign msb       = sr_q[7];
   assign data      = sr_q;
   assign byte_done = (cnt_q == 3'd0);

endmodule
`default_nettype wire

// File: rtl/mcu_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : mcu_spi_master
// Brief    : SPI mode-1 initiator for MCU-style frames: SS low, one target-ID
//            byte, then one or more payload bytes, MSB first, full duplex.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_spi_master
   import mcu_spi_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int IDLE_GAP = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] target,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_first,
   output logic       busy,
   output logic       spi_io_ss,
   output logic       spi_io_clk,
   output logic       spi_io_dout,
   input  logic       spi_io_din
);

   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int GW = $clog2(IDLE_GAP + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);
   localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);

   spi_state_e    state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    target_q, target_d;
   logic          last_q, last_d;
   logic          first_q, first_d;
   logic          dout_q, dout_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_first_q, rx_first_d;
   logic [7:0]    rx_data_q, rx_data_d;

   logic          sh_load, sh_shift, sh_msb, sh_done;
   logic [7:0]    sh_load_data, sh_data;

   logic          div_end, gap_end;
   assign div_end = (div_q == DIV_LAST);
   assign gap_end = (gap_q == GAP_LAST);

   spi_shift8 u_shift (
      .clk       (clk),
      .reset     (reset),
      .load      (sh_load),
      .load_data (sh_load_data),
      .shift     (sh_shift),
      .din       (spi_io_din),
      .msb       (sh_msb),
      .data      (sh_data),
      .byte_done (sh_done)
   );

   // Frame sequencer: next state, counters, shifter control and rx strobe
   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      gap_d        = gap_q;
      target_d     = target_q;
      last_d       = last_q;
      first_d      = first_q;
      dout_d       = dout_q;
      rx_valid_d   = 1'b0;
      rx_first_d   = 1'b0;
      rx_data_d    = rx_data_q;
      sh_load      = 1'b0;
      sh_load_data = 8'd0;
      sh_shift     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               target_d = target;
               last_d   = 1'b0;
               first_d  = 1'b1;
               div_d    = '0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            if (div_end) begin
               div_d        = '0;
               sh_load      = 1'b1;
               sh_load_data = target_q;
               state_d      = HI;
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         HI: begin
            // dout_q remembers the bit so it stays put through the low phase
            dout_d = sh_msb;
            if (div_end) begin
               div_d    = '0;
               sh_shift = 1'b1;
               state_d  = LO;
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         LO: begin
            if (div_end) begin
               div_d = '0;
               if (sh_done) begin
                  rx_valid_d = 1'b1;
                  rx_first_d = first_q;
                  rx_data_d  = sh_data;
                  state_d    = last_q ? HOLD : LOAD;
               end else begin
                  state_d = HI;
               end
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         LOAD: begin
            if (tx_valid) begin
               sh_load      = 1'b1;
               sh_load_data = tx_data;
               last_d       = tx_last;
               first_d      = 1'b0;
               state_d      = HI;
            end
         end
         HOLD: begin
            if (div_end) begin
               div_d   = '0;
               gap_d   = '0;
               state_d = GAP;
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         GAP: begin
            if (gap_end) begin
               gap_d   = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + GAP_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer registers; reset also drops a coincident start
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         div_q      <= '0;
         gap_q      <= '0;
         target_q   <= 8'd0;
         last_q     <= 1'b0;
         first_q    <= 1'b0;
         dout_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_first_q <= 1'b0;
         rx_data_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         gap_q      <= gap_d;
         target_q   <= target_d;
         last_q     <= last_d;
         first_q    <= first_d;
         dout_q     <= dout_d;
         rx_valid_q <= rx_valid_d;
         rx_first_q <= rx_first_d;
         rx_data_q  <= rx_data_d;
      end
   end

   // In HI the shifter MSB drives the line directly so dout moves with the
   // rising SCLK edge; elsewhere the last driven bit is held
   assign spi_io_dout = (state_q == HI) ? sh_msb : dout_q;
   assign spi_io_clk  = (state_q == HI);
   assign spi_io_ss   = (state_q == IDLE) || (state_q == GAP);
   assign busy        = (state_q != IDLE);
   assign tx_ready    = (state_q == LOAD);
   assign rx_valid    = rx_valid_q;
   assign rx_first    = rx_first_q;
   assign rx_data     = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mcu_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_spi_master
// Brief    : Scoreboard bench for mcu_spi_master (two parameterisations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcu_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, tx_valid, tx_last, sel, loop, din_const;
   logic [7:0] target, tx_data;
   logic       start0, start1, din0, din1;
   logic       tx_ready0, rx_valid0, rx_first0, busy0, ss0, sclk0, dout0;
   logic       tx_ready1, rx_valid1, rx_first1, busy1, ss1, sclk1, dout1;
   logic [7:0] rx_data0, rx_data1;
   logic       tx_ready_s, rx_valid_s, rx_first_s, busy_s, ss_s, sclk_s, dout_s;
   logic [7:0] rx_data_s;
   int         cur_div, cur_gap;

   assign start0 = start & ~sel;
   assign start1 = start & sel;
   assign din0   = loop ? dout0 : din_const;
   assign din1   = loop ? dout1 : din_const;

   assign tx_ready_s = sel ? tx_ready1 : tx_ready0;
   assign rx_valid_s = sel ? rx_valid1 : rx_valid0;
   assign rx_first_s = sel ? rx_first1 : rx_first0;
   assign rx_data_s  = sel ? rx_data1  : rx_data0;
   assign busy_s     = sel ? busy1     : busy0;
   assign ss_s       = sel ? ss1       : ss0;
   assign sclk_s     = sel ? sclk1     : sclk0;
   assign dout_s     = sel ? dout1     : dout0;

   mcu_spi_master #(.CLK_DIV(2), .IDLE_GAP(4)) u_dut0 (
      .clk(clk), .reset(reset), .start(start0), .target(target),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
      .rx_first(rx_first0), .busy(busy0), .spi_io_ss(ss0),
      .spi_io_clk(sclk0), .spi_io_dout(dout0), .spi_io_din(din0)
   );

   mcu_spi_master #(.CLK_DIV(1), .IDLE_GAP(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .target(target),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
      .rx_first(rx_first1), .busy(busy1), .spi_io_ss(ss1),
      .spi_io_clk(sclk1), .spi_io_dout(dout1), .spi_io_din(din1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard queues: MOSI bytes, rx bytes {first,data}, edges per frame
   logic [7:0] exp_mosi[$];
   logic [8:0] exp_rx[$];
   int         exp_edges[$];
   logic [7:0] pay[8];

   // Reference: what the responder returns for a byte in each din mode
   function automatic logic [7:0] rx_model(input logic [7:0] b, input int mode);
      if (mode == 0) return b;
      if (mode == 1) return 8'h00;
      return 8'hFF;
   endfunction

   // Monitor: reassembles MOSI bytes, checks rx strobes, SCLK shape, framing
   initial begin
      logic       prev_sclk, prev_ss, prev_dout, dout_moved;
      logic [7:0] mosi_sh, e8;
      logic [8:0] e9;
      int         nbits, edges, hi_cnt;
      prev_sclk = 0; prev_ss = 1; prev_dout = 0; dout_moved = 0;
      mosi_sh = 0; nbits = 0; edges = 0; hi_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_mosi.delete(); exp_rx.delete(); exp_edges.delete();
            nbits = 0; edges = 0; hi_cnt = 0; dout_moved = 0;
         end else begin
            if (sclk_s && !prev_sclk) begin
               check("mode1_dout_only_at_rise", dout_moved, 0);
               dout_moved = 0;
               mosi_sh = {mosi_sh[6:0], dout_s};
               nbits++; edges++;
               if (nbits == 8) begin
                  nbits = 0;
                  if (exp_mosi.size() == 0) check("mosi_unexpected_byte", mosi_sh, -1);
                  else begin
                     e8 = exp_mosi.pop_front();
                     check("mosi_byte", mosi_sh, e8);
                  end
               end
            end else if (!ss_s && !prev_ss && dout_s != prev_dout) begin
               dout_moved = 1;
            end
            if (!sclk_s && prev_sclk) check("sclk_high_width", hi_cnt, cur_div);
            hi_cnt = sclk_s ? hi_cnt + 1 : 0;
            if (rx_valid_s) begin
               if (exp_rx.size() == 0) check("rx_unexpected", rx_data_s, -1);
               else begin
                  e9 = exp_rx.pop_front();
                  check("rx_data", rx_data_s, e9[7:0]);
                  check("rx_first", rx_first_s, e9[8]);
               end
            end
            if (ss_s && !prev_ss) begin
               if (exp_edges.size() == 0) check("frame_unexpected", edges, -1);
               else check("edges_per_frame", edges, exp_edges.pop_front());
               edges = 0;
            end
         end
         prev_sclk = sclk_s; prev_ss = ss_s; prev_dout = dout_s;
      end
   end

   // Issues one frame; din_mode 0=loopback 1=const0 2=const1
   task automatic run_frame(input logic [7:0] tgt, input int n, input int din_mode,
                            input int stall_byte, input bit start_mid,
                            input bit start_gap, input int reset_at_edge);
      int k, gap, e;
      logic prev, bad;
      @(negedge clk);
      k = 0;
      while (busy_s && k < 200) begin @(negedge clk); k++; end
      check("idle_before_start", busy_s, 0);
      loop = (din_mode == 0);
      din_const = (din_mode == 2);
      exp_mosi.push_back(tgt);
      exp_rx.push_back({1'b1, rx_model(tgt, din_mode)});
      for (int i = 0; i < n; i++) begin
         exp_mosi.push_back(pay[i]);
         exp_rx.push_back({1'b0, rx_model(pay[i], din_mode)});
      end
      exp_edges.push_back(8 * (n + 1));
      start = 1; target = tgt;
      @(negedge clk);
      start = 0;
      check("ss_low_after_start", ss_s, 0);
      k = 0;
      while (!sclk_s && k < 50) begin @(negedge clk); k++; end
      check("first_edge_delay", k, cur_div);
      for (int i = 0; i < n; i++) begin
         k = 0;
         while (!tx_ready_s && k < 200) begin
            tx_valid = 1'($urandom); tx_data = 8'($urandom); tx_last = 1'($urandom);
            @(negedge clk); k++;
         end
         tx_valid = 0;
         check("tx_ready_before_byte", tx_ready_s, 1);
         if (start_mid && i == 0) begin
            start = 1; target = 8'hEE;
            @(negedge clk);
            start = 0;
            check("start_ignored_while_busy", tx_ready_s, 1);
         end
         if (stall_byte == i) begin
            bad = 0;
            repeat (20) begin
               @(negedge clk);
               if (sclk_s || ss_s || !tx_ready_s) bad = 1;
            end
            check("stall_lines_quiet", bad, 0);
         end
         tx_data = pay[i]; tx_last = (i == n - 1); tx_valid = 1;
         @(negedge clk);
         tx_valid = 0; tx_last = 0; tx_data = 8'($urandom);
         check("edge_after_load", sclk_s, 1);
         if (reset_at_edge > 0 && i == 0) begin
            prev = 1; e = 1; k = 0;
            while (e < reset_at_edge && k < 200) begin
               @(negedge clk); k++;
               if (sclk_s && !prev) e++;
               prev = sclk_s;
            end
            check("reset_edge_reached", e, reset_at_edge);
            reset = 1;
            @(negedge clk);
            check("midreset_ss", ss_s, 1);
            check("midreset_sclk", sclk_s, 0);
            check("midreset_busy", busy_s, 0);
            check("midreset_rx_valid", rx_valid_s, 0);
            check("midreset_dout", dout_s, 0);
            @(negedge clk);
            reset = 0;
            return;
         end
      end
      k = 0;
      while (!ss_s && k < 400) begin @(negedge clk); k++; end
      gap = 0; k = 0;
      while (busy_s && k < 100) begin
         if (ss_s) gap++;
         start = (start_gap && gap == 1);
         if (start) target = 8'hEE;
         @(negedge clk); k++;
      end
      start = 0;
      check("gap_length", gap, cur_gap);
      @(negedge clk);
      check("no_restart_after_gap", busy_s, 0);
   endtask

   // Watchdog so a stuck design cannot hang the run
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1; start = 0; target = 0; tx_data = 0; tx_valid = 0; tx_last = 0;
      sel = 0; loop = 1; din_const = 0; cur_div = 2; cur_gap = 4;
      repeat (3) @(negedge clk);
      check("rst_ss", ss0, 1);
      check("rst_sclk", sclk0, 0);
      check("rst_dout", dout0, 0);
      check("rst_tx_ready", tx_ready0, 0);
      check("rst_rx_valid", rx_valid0, 0);
      check("rst_rx_first", rx_first0, 0);
      check("rst_busy", busy0, 0);
      check("rst_rx_data", rx_data0, 0);
      check("rst_ss_div1", ss1, 1);
      check("rst_busy_div1", busy1, 0);
      reset = 0;
      @(negedge clk);
      reset = 1; start = 1; target = 8'h77;
      @(negedge clk);
      reset = 0; start = 0;
      @(negedge clk);
      check("start_with_reset_dropped", busy0, 0);

      // Basic loopback frame
      pay[0] = 8'hA5; pay[1] = 8'h3C;
      run_frame(8'h02, 2, 0, -1, 0, 0, 0);
      // Responder returns all ones
      pay[0] = 8'($urandom); pay[1] = 8'($urandom);
      run_frame(mcu_spi_pkg::TARGET_HID, 2, 2, -1, 0, 0, 0);
      // Stall in LOAD before the first payload byte
      pay[0] = 8'($urandom); pay[1] = 8'($urandom);
      run_frame(mcu_spi_pkg::TARGET_OSD, 2, 0, 0, 0, 0, 0);
      // start during the frame and during GAP
      pay[0] = 8'($urandom); pay[1] = 8'($urandom); pay[2] = 8'($urandom);
      run_frame(8'h5A, 3, 0, -1, 1, 1, 0);
      // Reset on the third rising edge of payload byte 1, then a clean frame
      pay[0] = 8'hC3; pay[1] = 8'h99;
      run_frame(8'h33, 2, 0, -1, 0, 0, 3);
      pay[0] = 8'h55;
      run_frame(mcu_spi_pkg::TARGET_HID, 1, 0, -1, 0, 0, 0);
      // Randomised frames
      for (int f = 0; f < 6; f++) begin
         int n;
         n = int'($urandom_range(1, 4));
         for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
         run_frame(8'($urandom), n, int'($urandom_range(0, 2)),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1,
                   0, 0, 0);
      end

      // Fastest divider instance
      @(negedge clk);
      sel = 1; cur_div = 1; cur_gap = 1;
      pay[0] = 8'h80;
      run_frame(mcu_spi_pkg::TARGET_OSD, 1, 0, -1, 0, 0, 0);
      for (int f = 0; f < 2; f++) begin
         pay[0] = 8'($urandom); pay[1] = 8'($urandom);
         run_frame(8'($urandom), 2, int'($urandom_range(0, 2)), f, 0, 0, 0);
      end

      repeat (10) @(negedge clk);
      check("mosi_queue_drained", exp_mosi.size(), 0);
      check("rx_queue_drained", exp_rx.size(), 0);
      check("frame_queue_drained", exp_edges.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
